unified_butterfly: RTL and testbench
====================================

# unified_butterfly

Parametrised radix-2 butterfly for the NTT/INTT datapath. It runs Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT) per sample, selected by a mode bit. It adds optional divide-by-2 on the GS outputs, so the final INTT scaling by n⁻¹ is folded into the last stage. It has a valid-qualified fixed-latency pipeline and replaces the GS-only butterfly in both NTT and INTT stage controllers.

## Interface
- WIDTH, 30: coefficient/twiddle width; all values in [0, q).
- MOD_INDEX, 0: index into the shared modulus table; selects q.
- MULT_LAT, 4: latency of `modular_multiplier` in cycles; must be ≥1.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample A/B/w/mode/halve this cycle.
- mode  in  1  0 = CT, 1 = GS.
- halve  in  1  GS only: output (x·2⁻¹ mod q); ignored when mode=0.
- A, B, w  in  WIDTH each  operands and twiddle.
- out_valid  out  1  a/b hold a result this cycle.
- a, b  out  WIDTH each  butterfly outputs.
- busy  out  1  any sample in flight.

## Operation
- CT (mode=0): a = (A + B·w) mod q, b = (A − B·w) mod q.
- GS (mode=1): a = (A + B) mod q, b = ((A − B)·w) mod q. With halve=1, both outputs are replaced by h(x).
- h(x): x even → x>>1; x odd → (x+q)>>1, computed with WIDTH+1 bits. Result is always < q.
- Stage P (pre), 1 cycle:
  - registers A, B, w, mode, halve, valid.
  - pre add/sub computes A+B and A−B (registered).
- Multiplier input is muxed on the registered mode: B_reg (CT) or diff_reg (GS), times w_reg. Both modes therefore enter the multiplier on the same cycle, and mode may change every sample with no hazard or bubble.
- A_reg (CT) or sum_reg (GS) is delayed MULT_LAT cycles alongside the product. Mode and halve are delayed the same way.
- Stage O (post), 1 cycle: registered output.
  - CT: post add/sub produces a = A_d + m, b = A_d − m.
  - GS: a = sum_d, b = m, each passed through h() if halve_d.
- A valid shift register of depth LAT tracks in-flight samples. busy = OR of all valid stages.
- Data registers are not qualified by valid. Outputs are only defined while out_valid=1, except at reset.
- No backpressure. The block accepts one sample per cycle unconditionally.

## Timing
- LAT = MULT_LAT + 2 for both modes (6 by default).
- A sample taken at edge t appears with out_valid=1 after edge t+LAT−1, i.e. for exactly one cycle, LAT cycles later. Outputs keep input order.
- Back-to-back in_valid gives back-to-back out_valid with the same gaps as the input.
- Reset (rst_n low, any time):
  - out_valid=0, a=0, b=0, busy=0 immediately.
  - All in-flight samples are discarded; none emerge after deassertion.
- First sample accepted on the first rising edge with rst_n high.
- in_valid=0 cycles produce out_valid=0 LAT cycles later. a/b values in those cycles are don't-care.

## Structure
- Shared package `ntt_pkg` holds:
  - the modulus table and accessor function q(MOD_INDEX);
  - the default WIDTH;
  - mode encoding constants MODE_CT=0, MODE_GS=1.
- Reuses `modular_adder`, `modular_subtractor` (1-cycle registered) and `modular_multiplier` (MULT_LAT). Adder/subtractor are instantiated twice, pre and post.
- One new combinational sub-module, `mod_halve` (WIDTH, MOD_INDEX), implements h(). It is instantiated twice in stage O.

## Test plan
- Reset mid-stream: run 3 valid samples, then pulse rst_n low for 1 cycle → out_valid and busy drop immediately; no output ever appears for those samples; a=b=0.
- CT basic: A=5, B=3, w=2, mode=0 → exactly LAT cycles later a=11, b=q−1, out_valid high for one cycle; busy high during flight.
- GS basic and halving: A=5, B=3, w=7, mode=1, halve=0 → a=8, b=14. Same with halve=1 → a=4, b=7.
- GS wrap and odd halving: A=3, B=5, w=1, mode=1 → halve=0: a=8, b=q−2; halve=1: a=4, b=q−1.
- Mode interleave: 16 consecutive samples alternating CT/GS with random operands (random halve) → 16 consecutive out_valid cycles, each matching the reference model in order.
- Bubbles and extremes: A=B=q−1, w=q−1 in both modes, with in_valid gaps of 0/1/3 cycles → results match the model, output gaps equal input gaps, busy drops LAT cycles after the last sample.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: constants shared by the NTT/INTT datapath blocks.
//   DEFAULT_WIDTH  default coefficient / twiddle width
//   MODE_CT/MODE_GS  butterfly mode encoding (Cooley-Tukey / Gentleman-Sande)
//   q(idx)         modulus table accessor; every entry is odd and < 2**DEFAULT_WIDTH
package ntt_pkg;

   localparam int   DEFAULT_WIDTH = 30;
   localparam logic MODE_CT       = 1'b0;
   localparam logic MODE_GS       = 1'b1;
   localparam int   NUM_MODULI    = 4;

   // NTT-friendly primes. Oddness matters: mod_halve relies on q being odd
   // so that 2 has an inverse.
   function automatic logic [63:0] q(input int idx);
      logic [63:0] val;
      case (idx)
         0:       val = 64'd998244353;
         1:       val = 64'd469762049;
         2:       val = 64'd167772161;
         3:       val = 64'd754974721;
         default: val = 64'd998244353;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/mod_halve.sv
// mod_halve: combinational x * 2^-1 mod q.
//   x  value in [0, q)
//   y  x/2 for even x, (x+q)/2 for odd x; always in [0, q)
// q is odd, so x+q is even whenever x is odd; WIDTH+1 bits hold x+q.
module mod_halve
   import ntt_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MOD_INDEX = 0
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   localparam logic [WIDTH:0] Q = (WIDTH+1)'(q(MOD_INDEX));

   logic [WIDTH:0] ext;

   always_comb begin
      ext = x[0] ? ({1'b0, x} + Q) : {1'b0, x};
      y   = WIDTH'(ext >> 1);
   end

endmodule

// File: rtl/modular_adder.sv
// modular_adder: registered (x + y) mod q, one cycle of latency.
//   clk, rst_n  clock, asynchronous active-low reset (clears s)
//   x, y        operands in [0, q)
//   s           registered sum in [0, q)
module modular_adder
   import ntt_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MOD_INDEX = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] s
);

   localparam logic [WIDTH:0] Q = (WIDTH+1)'(q(MOD_INDEX));

   logic [WIDTH:0]   sum_full;
   logic [WIDTH-1:0] sum_red;

   // Operands are below q, so one conditional subtraction is enough.
   always_comb begin
      sum_full = {1'b0, x} + {1'b0, y};
      sum_red  = WIDTH'((sum_full >= Q) ? (sum_full - Q) : sum_full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s <= '0;
      else        s <= sum_red;
   end

endmodule

// File: rtl/modular_multiplier.sv
// modular_multiplier: (x * y) mod q with MULT_LAT cycles of latency.
//   clk, rst_n  clock, asynchronous active-low reset (clears the pipeline)
//   x, y        operands in [0, q)
//   p           product in [0, q), MULT_LAT cycles after x/y were presented
// MULT_LAT must be at least 1. The reduction is done up front and the
// remaining stages are retiming registers for the synthesis tool to use.
module modular_multiplier
   import ntt_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MOD_INDEX = 0,
   parameter int MULT_LAT  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] p
);

   localparam logic [2*WIDTH-1:0] Q2 = (2*WIDTH)'(q(MOD_INDEX));

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   prod_red;
   logic [WIDTH-1:0]   pipe [MULT_LAT];

   always_comb begin
      prod     = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
      prod_red = WIDTH'(prod % Q2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MULT_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= prod_red;
         for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign p = pipe[MULT_LAT-1];

endmodule

// File: rtl/modular_subtractor.sv
// modular_subtractor: registered (x - y) mod q, one cycle of latency.
//   clk, rst_n  clock, asynchronous active-low reset (clears d)
//   x, y        operands in [0, q)
//   d           registered difference in [0, q)
module modular_subtractor
   import ntt_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MOD_INDEX = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] d
);

   localparam logic [WIDTH:0] Q = (WIDTH+1)'(q(MOD_INDEX));

   logic [WIDTH-1:0] diff_red;

   // When y > x add q back before subtracting; WIDTH+1 bits cannot overflow.
   always_comb begin
      diff_red = WIDTH'((x >= y) ? ({1'b0, x} - {1'b0, y})
                                 : ({1'b0, x} + Q - {1'b0, y}));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d <= '0;
      else        d <= diff_red;
   end

endmodule

// File: rtl/unified_butterfly.sv
// unified_butterfly: radix-2 CT/GS butterfly with optional GS halving.
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        sample A/B/w/mode/halve this cycle
//   mode            MODE_CT: a=A+B*w, b=A-B*w
//                   MODE_GS: a=A+B,   b=(A-B)*w  (each halved when halve=1)
//   halve           GS only; ignored in CT
//   A, B, w         operands / twiddle in [0, q)
//   out_valid       a/b hold a result this cycle
//   a, b            butterfly outputs
//   busy            any sample in flight
// Handshake: in_valid is a pure qualifier, there is no ready. One sample is
// accepted every cycle in_valid is high; out_valid pulses exactly
// LAT = MULT_LAT+2 cycles later, in input order, with the same gaps.
// Pipeline: P (pre add/sub + operand regs) -> multiplier (MULT_LAT)
// -> O (post add/sub or halving). Both modes have the same latency, so the
// mode may change every sample.
module unified_butterfly
   import ntt_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MOD_INDEX = 0,
   parameter int MULT_LAT  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             mode,
   input  logic             halve,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] w,
   output logic             out_valid,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             busy
);

   // ---------------- stage P ----------------
   logic [WIDTH-1:0] opa_p, opb_p, tw_p;
   logic [WIDTH-1:0] sum_p, diff_p;
   logic             mode_p, halve_p, valid_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_p   <= '0;
         opb_p   <= '0;
         tw_p    <= '0;
         mode_p  <= MODE_CT;
         halve_p <= 1'b0;
         valid_p <= 1'b0;
      end else begin
         opa_p   <= A;
         opb_p   <= B;
         tw_p    <= w;
         mode_p  <= mode;
         halve_p <= halve;
         valid_p <= in_valid;
      end
   end

   modular_adder #(.WIDTH(WIDTH), .MOD_INDEX(MOD_INDEX)) u_pre_add (
      .clk(clk), .rst_n(rst_n), .x(A), .y(B), .s(sum_p)
   );

   modular_subtractor #(.WIDTH(WIDTH), .MOD_INDEX(MOD_INDEX)) u_pre_sub (
      .clk(clk), .rst_n(rst_n), .x(A), .y(B), .d(diff_p)
   );

   // ---------------- multiplier + side delay line ----------------
   // CT multiplies B by w, GS multiplies (A-B) by w; the other operand
   // (A for CT, A+B for GS) rides alongside the product.
   logic [WIDTH-1:0] mul_x, lhs_p, prod_m;

   always_comb begin
      mul_x = (mode_p == MODE_GS) ? diff_p : opb_p;
      lhs_p = (mode_p == MODE_GS) ? sum_p  : opa_p;
   end

   modular_multiplier #(.WIDTH(WIDTH), .MOD_INDEX(MOD_INDEX), .MULT_LAT(MULT_LAT)) u_mul (
      .clk(clk), .rst_n(rst_n), .x(mul_x), .y(tw_p), .p(prod_m)
   );

   logic [WIDTH-1:0]    lhs_d [MULT_LAT];
   logic [MULT_LAT-1:0] mode_d, halve_d, valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MULT_LAT; i++) lhs_d[i] <= '0;
         mode_d  <= '0;
         halve_d <= '0;
         valid_d <= '0;
      end else begin
         lhs_d[0]   <= lhs_p;
         mode_d[0]  <= mode_p;
         halve_d[0] <= halve_p;
         valid_d[0] <= valid_p;
         for (int i = 1; i < MULT_LAT; i++) begin
            lhs_d[i]   <= lhs_d[i-1];
            mode_d[i]  <= mode_d[i-1];
            halve_d[i] <= halve_d[i-1];
            valid_d[i] <= valid_d[i-1];
         end
      end
   end

   logic [WIDTH-1:0] lhs_m;
   logic             mode_m, halve_m, valid_m;

   assign lhs_m   = lhs_d[MULT_LAT-1];
   assign mode_m  = mode_d[MULT_LAT-1];
   assign halve_m = halve_d[MULT_LAT-1];
   assign valid_m = valid_d[MULT_LAT-1];

   // ---------------- stage O ----------------
   // CT results come from the registered post add/sub; GS results are
   // registered here in parallel. The final select uses the registered
   // mode, so a/b are a mux of flops and read zero during reset.
   logic [WIDTH-1:0] ct_a, ct_b;
   logic [WIDTH-1:0] h_lhs, h_prod;
   logic [WIDTH-1:0] gs_a, gs_b;
   logic             mode_o, valid_o;

   modular_adder #(.WIDTH(WIDTH), .MOD_INDEX(MOD_INDEX)) u_post_add (
      .clk(clk), .rst_n(rst_n), .x(lhs_m), .y(prod_m), .s(ct_a)
   );

   modular_subtractor #(.WIDTH(WIDTH), .MOD_INDEX(MOD_INDEX)) u_post_sub (
      .clk(clk), .rst_n(rst_n), .x(lhs_m), .y(prod_m), .d(ct_b)
   );

   mod_halve #(.WIDTH(WIDTH), .MOD_INDEX(MOD_INDEX)) u_halve_a (
      .x(lhs_m), .y(h_lhs)
   );

   mod_halve #(.WIDTH(WIDTH), .MOD_INDEX(MOD_INDEX)) u_halve_b (
      .x(prod_m), .y(h_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gs_a    <= '0;
         gs_b    <= '0;
         mode_o  <= MODE_CT;
         valid_o <= 1'b0;
      end else begin
         gs_a    <= halve_m ? h_lhs  : lhs_m;
         gs_b    <= halve_m ? h_prod : prod_m;
         mode_o  <= mode_m;
         valid_o <= valid_m;
      end
   end

   assign a         = (mode_o == MODE_GS) ? gs_a : ct_a;
   assign b         = (mode_o == MODE_GS) ? gs_b : ct_b;
   assign out_valid = valid_o;
   assign busy      = valid_p | (|valid_d) | valid_o;

endmodule

// File: tb/tb_unified_butterfly.sv
// Testbench for unified_butterfly (default parameters, q = 998244353).
module tb_unified_butterfly;

   localparam int     WIDTH    = 30;
   localparam int     MULT_LAT = 4;
   localparam int     LAT      = MULT_LAT + 2;
   localparam longint Q        = 64'd998244353;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             mode = 1'b0;
   logic             halve = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic [WIDTH-1:0] w = '0;
   logic             out_valid;
   logic [WIDTH-1:0] a, b;
   logic             busy;

   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   unified_butterfly #(.WIDTH(WIDTH), .MOD_INDEX(0), .MULT_LAT(MULT_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .halve(halve),
      .A(A), .B(B), .w(w), .out_valid(out_valid), .a(a), .b(b), .busy(busy)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      int               exp_cyc;
      logic [WIDTH-1:0] ea;
      logic [WIDTH-1:0] eb;
      bit               lit;
      logic [WIDTH-1:0] la;
      logic [WIDTH-1:0] lb;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint half_mod(input longint x);
      return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input longint av, input longint bv, input longint wv,
                       input bit md, input bit hv,
                       input bit lit, input longint la, input longint lb);
      exp_t   e;
      longint m, ea, eb;
      if (md == 1'b0) begin
         m  = (bv * wv) % Q;
         ea = (av + m) % Q;
         eb = (av - m + Q) % Q;
      end else begin
         ea = (av + bv) % Q;
         eb = (((av - bv + Q) % Q) * wv) % Q;
         if (hv) begin
            ea = half_mod(ea);
            eb = half_mod(eb);
         end
      end
      A        = WIDTH'(av);
      B        = WIDTH'(bv);
      w        = WIDTH'(wv);
      mode     = md;
      halve    = hv;
      in_valid = 1'b1;
      e.exp_cyc = cyc + LAT;
      e.ea      = WIDTH'(ea);
      e.eb      = WIDTH'(eb);
      e.lit     = lit;
      e.la      = WIDTH'(la);
      e.lb      = WIDTH'(lb);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
      check({tag, "_a"},         64'(a),         64'd0);
      check({tag, "_b"},         64'(b),         64'd0);
   endtask

   function automatic longint rnd_val();
      return longint'($urandom_range(int'(Q - 1), 0));
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin : compare
      bit   exp_busy;
      exp_t e;
      if (rst_n) begin
         exp_busy = 1'b0;
         foreach (exp_q[i])
            if (exp_q[i].exp_cyc - LAT + 1 <= cyc) exp_busy = 1'b1;
         check("busy", 64'(busy), 64'(exp_busy));
         if (exp_q.size() > 0 && exp_q[0].exp_cyc == cyc) begin
            e = exp_q.pop_front();
            check("out_valid", 64'(out_valid), 64'd1);
            check("a", 64'(a), 64'(e.ea));
            check("b", 64'(b), 64'(e.eb));
            if (e.lit) begin
               check("a_literal", 64'(a), 64'(e.la));
               check("b_literal", 64'(b), 64'(e.lb));
            end
         end else begin
            check("out_valid_idle", 64'(out_valid), 64'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;

      // CT basic, sent on the first edge after reset release
      send(5, 3, 2, 1'b0, 1'b0, 1'b1, 11, Q - 1);
      idle(LAT + 1);

      // GS basic / halving / wrap / odd halving, back to back
      send(5, 3, 7, 1'b1, 1'b0, 1'b1, 8, 14);
      send(5, 3, 7, 1'b1, 1'b1, 1'b1, 4, 7);
      send(3, 5, 1, 1'b1, 1'b0, 1'b1, 8, Q - 2);
      send(3, 5, 1, 1'b1, 1'b1, 1'b1, 4, Q - 1);
      idle(LAT + 1);

      // reset mid-stream: three samples in flight are dropped
      for (int i = 0; i < 3; i++)
         send(rnd_val(), rnd_val(), rnd_val(), 1'(i % 2), 1'b0, 1'b0, 0, 0);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(LAT + 3);

      // mode interleave, 16 consecutive samples
      for (int i = 0; i < 16; i++)
         send(rnd_val(), rnd_val(), rnd_val(), 1'(i % 2), 1'($urandom_range(1, 0)),
              1'b0, 0, 0);
      idle(LAT + 1);

      // extremes with input gaps of 0, 1 and 3 cycles
      send(Q - 1, Q - 1, Q - 1, 1'b0, 1'b0, 1'b1, 0, Q - 2);
      send(Q - 1, Q - 1, Q - 1, 1'b1, 1'b0, 1'b1, Q - 2, 0);
      idle(1);
      send(Q - 1, Q - 1, Q - 1, 1'b1, 1'b1, 1'b1, Q - 1, 0);
      idle(3);
      send(Q - 1, Q - 1, Q - 1, 1'b0, 1'b1, 1'b1, 0, Q - 2);
      idle(LAT + 3);

      check("drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
